// File: rtl/abs_diff_err_monitor.sv
// Exhaustive-sweep error monitor for approximate |a-b| circuits: drives every
// operand pair, compares the returned result with the exact value, accumulates stats.
module abs_diff_err_monitor #(
    parameter int W       = 2,
    parameter int OUT_W   = 2,
    parameter int ET      = 2,
    parameter int DUT_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic [2*W-1:0]         vec_o,
    input  logic [OUT_W-1:0]       dut_out_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [OUT_W:0]         max_err_o,
    output logic [2*W+OUT_W:0]     err_sum_o,
    output logic [2*W:0]           viol_cnt_o,
    output logic                   fail_vld_o,
    output logic [2*W-1:0]         fail_vec_o
);

    localparam int EW    = OUT_W + 1;
    localparam int SW    = 2*W + OUT_W + 1;
    localparam int CW    = 2*W + 1;
    localparam int CNT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [EW-1:0]    err;
    logic [EW-1:0]    max_nxt;
    logic             viol;

    function automatic logic [W-1:0] abs_exact(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_exact = (d < 0) ? W'(-d) : W'(d);
    endfunction

    // The error is formed in OUT_W+2 signed bits so dut-exact never overflows.
    function automatic logic [EW-1:0] abs_err(input logic [OUT_W-1:0] dut, input logic [W-1:0] exact);
        logic signed [OUT_W+1:0] e;
        e = $signed({2'b00, dut}) - $signed({{(OUT_W+2-W){1'b0}}, exact});
        abs_err = (e < 0) ? EW'(-e) : EW'(e);
    endfunction

    always_comb begin
        err     = abs_err(dut_out_i, abs_exact(vec_o[W-1:0], vec_o[2*W-1:W]));
        viol    = (err > EW'(ET));
        max_nxt = (err > max_err_o) ? err : max_err_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            vec_o      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            max_err_o  <= '0;
            err_sum_o  <= '0;
            viol_cnt_o <= '0;
            fail_vld_o <= 1'b0;
            fail_vec_o <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state      <= S_DRIVE;
                        vec_o      <= '0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        pass_o     <= 1'b0;
                        max_err_o  <= '0;
                        err_sum_o  <= '0;
                        viol_cnt_o <= '0;
                        fail_vld_o <= 1'b0;
                        fail_vec_o <= '0;
                    end
                end
                S_DRIVE: begin
                    wait_cnt <= '0;
                    state    <= (DUT_LAT > 0) ? S_WAIT : S_EVAL;
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(DUT_LAT - 1)) begin
                        state <= S_EVAL;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    max_err_o <= max_nxt;
                    err_sum_o <= err_sum_o + SW'(err);
                    if (viol) begin
                        viol_cnt_o <= viol_cnt_o + CW'(1);
                        if (!fail_vld_o) begin
                            fail_vld_o <= 1'b1;
                            fail_vec_o <= vec_o;
                        end
                    end
                    // The all-ones vector is terminal; vec_o is left holding it.
                    if (vec_o == '1) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (max_nxt <= EW'(ET));
                    end else begin
                        vec_o <= vec_o + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/abs_diff_err_monitor.md
# abs_diff_err_monitor

Sequential exhaustive-sweep error monitor for the approximate 2-operand absolute-difference circuits. It drives every input vector into a combinational or pipelined approximate abs_diff DUT and reads back the DUT result. For each vector it computes the exact |a−b| and accumulates error statistics: max error, error sum, count of vectors over the error threshold, and the first failing vector. It sits on the consuming side of the approximate circuit's input/output interface, in the on-chip characterisation harness.

## Interface
- `W`, default 2: operand width; DUT input width is 2·W.
- `OUT_W`, default 2: DUT result width (≥ W).
- `ET`, default 2: error threshold; a vector violates when err > ET.
- `DUT_LAT`, default 0: DUT pipeline latency in cycles (0 = combinational).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_i`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `vec_o`  out  2W  stimulus to DUT; a = vec_o[W-1:0], b = vec_o[2W-1:W]; bit 0 maps to DUT in0.
- `dut_out_i`  in  OUT_W  DUT result; bit 0 = out0.
- `busy_o`  out  1  sweep in progress.
- `done_o`  out  1  level; sweep complete, results valid.
- `pass_o`  out  1  max_err_o ≤ ET; valid with done_o.
- `max_err_o`  out  OUT_W+1  largest |dut − exact|.
- `err_sum_o`  out  2W+OUT_W+1  sum of errors over all vectors.
- `viol_cnt_o`  out  2W+1  number of vectors with err > ET.
- `fail_vld_o`  out  1  at least one violation seen.
- `fail_vec_o`  out  2W  first violating vector, in sweep order.

## Operation
FSM states:
- **IDLE**: if start_i → DRIVE, load vec_o=0, clear all statistics.
- **DRIVE**: vec_o stable for one cycle; → WAIT if DUT_LAT>0, else → EVAL.
- **WAIT**: count DUT_LAT cycles, then → EVAL.
- **EVAL**: sample dut_out_i and update statistics.
  - If vec_o is all-ones → DONE.
  - Else vec_o+1 → DRIVE.
- **DONE**: hold results; start_i → DRIVE with stats cleared and vec_o=0.

Arithmetic:
- exact = |a−b|, W bits, zero-extended to OUT_W+1.
- dut zero-extended to OUT_W+1.
- err = |dut − exact|, computed in OUT_W+2-bit signed, result OUT_W+1 bits unsigned.
- max_err updates when err > max_err.
- err_sum accumulates err; sized so it cannot overflow.
- viol_cnt increments when err > ET.
- fail_vec latches on the first violation only; fail_vld is set at the same time.

Boundary and event rules:
- start_i is ignored in DRIVE/WAIT/EVAL.
- Terminal vector detection uses an all-ones compare. The counter does not wrap into a second sweep.
- rst_n low at any time forces the state to IDLE and clears all outputs immediately; a partial sweep is discarded.
- When a new start is accepted from DONE, done_o, pass_o, and all statistics clear on that edge.

## Timing
Reset values:
- vec_o=0, busy_o=0, done_o=0, pass_o=0, fail_vld_o=0.
- All counters and statistics 0.

Handshake and latency:
- start_i is sampled high at edge k; busy_o=1 and vec_o=0 from edge k.
- Each vector takes DUT_LAT+2 cycles. dut_out_i is sampled DUT_LAT+1 cycles after vec_o changes.
- done_o rises at edge k + 2^(2W)·(DUT_LAT+2). Default: k+32.
- busy_o falls on the same edge that done_o rises.
- Statistics registers update at EVAL edges. Outputs are direct register values with no extra output stage.
- vec_o holds the last vector (all-ones) in DONE.

## Test plan
- Exact reference DUT model, defaults → done_o at start+32; max_err=0, err_sum=0, viol_cnt=0, fail_vld=0, pass=1.
- dut_out_i tied 0 → max_err=3, err_sum=20, viol_cnt=2, fail_vld=1, fail_vec=4'b0011, pass=0.
- dut_out_i tied 2'b11 → max_err=3, err_sum=28, viol_cnt=4, fail_vec=4'b0000, pass=0.
- DUT_LAT=2, exact model with 2-cycle registered delay → done_o at start+64; all statistics 0, pass=1. With DUT_LAT=0 on the same delayed DUT, viol_cnt>0.
- start_i pulsed at cycles 5 and 10 after the first start → sweep unaffected, done still at start+32. Start in DONE → stats clear and a new sweep runs with identical results.
- rst_n low at cycle 12 of a sweep, released, then start → all outputs 0 during reset. The fresh sweep completes at start+32 with correct results.
